jk_mod_counter: RTL and testbench

//  Parametrised synchronous up/down modulo-N counter; each state bit is held in its own JK flip-flop cell.

---
 rtl/jk_mod_counter_pkg.sv | 13 +
 rtl/jk_mod_counter_jk_ff_cell.sv | 31 +++
 rtl/jk_mod_counter.sv | 114 +++++++++++
 tb/tb_jk_mod_counter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK-based counter family: count-mode encoding and width limits.
package jk_mod_counter_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_UP   = 2'd1,
        MODE_DOWN = 2'd2,
        MODE_LOAD = 2'd3
    } count_mode_e;

endpackage

// File: rtl/jk_mod_counter_jk_ff_cell.sv
// Single JK flip-flop with synchronous active-high reset to a per-cell value.
module jk_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    logic state;

    // NOTE: sequential state uses non-blocking assignments so every cell samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= rst_val;
        end else begin
            case ({j, k})
                2'b01:   state <= 1'b0;
                2'b10:   state <= 1'b1;
                2'b11:   state <= ~state;
                default: state <= state;
            endcase
        end
    end

    assign q  = state;
    assign qn = ~state;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-N counter built from JK cells, with load clamp, terminal count and wrap flags.
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("jk_mod_counter: WIDTH out of range");
    end

    localparam logic [WIDTH:0]   LAST  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0]   ONE   = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    count_mode_e      mode;
    logic [WIDTH:0]   cur;
    logic [WIDTH:0]   nxt_ext;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             wrap_nxt;
    logic             load_err_nxt;

    assign cur = {1'b0, q};

    always_comb begin
        if (load)    mode = MODE_LOAD;
        else if (en) mode = up_dn ? MODE_UP : MODE_DOWN;
        else         mode = MODE_HOLD;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        nxt_ext      = cur;
        wrap_nxt     = 1'b0;
        load_err_nxt = 1'b0;
        case (mode)
            MODE_LOAD: begin
                if ({1'b0, load_val} > LAST) begin
                    nxt_ext      = LAST;
                    load_err_nxt = 1'b1;
                end else begin
                    nxt_ext = {1'b0, load_val};
                end
            end
            // Out-of-range states (cur > LAST) are steered back into range and flagged as a wrap.
            MODE_UP: begin
                if (cur >= LAST) begin
                    nxt_ext  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt_ext = cur + ONE;
                end
            end
            MODE_DOWN: begin
                if (cur == '0 || cur > LAST) begin
                    nxt_ext  = LAST;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt_ext = cur - ONE;
                end
            end
            MODE_HOLD: ;
            default:   ;
        endcase
    end

    assign nxt = nxt_ext[WIDTH-1:0];

    // Excitation table: J and K are never both high, so a changing bit is always a set or a clear.
    assign j = nxt & ~q;
    assign k = ~nxt & q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_V[i]),
            .j       (j[i]),
            .k       (k[i]),
            .q       (q[i]),
            .qn      (qn[i])
        );
    end

    assign tc = up_dn ? (cur == LAST) : (cur == '0);

    // NOTE: reset is synchronous; only flag registers live here and both clear on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= wrap_nxt;
            load_err <= load_err_nxt;
        end
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench: two counter configurations checked against a modulo-arithmetic model.
module tb_jk_mod_counter;

    typedef struct packed {
        int q;
        bit wrap;
        bit lerr;
        bit tc;
        bit hold;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration A: WIDTH=4 MODULUS=10 RESET_VAL=0
    logic       rst_a = 0, en_a = 0, up_a = 0, load_a = 0;
    logic [3:0] lv_a = '0, q_a, qn_a;
    logic       tc_a, wrap_a, lerr_a;

    // Configuration B: WIDTH=3 MODULUS=8 RESET_VAL=5
    logic       rst_b = 0, en_b = 0, up_b = 0, load_b = 0;
    logic [2:0] lv_b = '0, q_b, qn_b;
    logic       tc_b, wrap_b, lerr_b;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .up_dn(up_a), .load(load_a), .load_val(lv_a),
        .q(q_a), .qn(qn_a), .tc(tc_a), .wrap(wrap_a), .load_err(lerr_a)
    );

    jk_mod_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(5)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .up_dn(up_b), .load(load_b), .load_val(lv_b),
        .q(q_b), .qn(qn_b), .tc(tc_b), .wrap(wrap_b), .load_err(lerr_b)
    );

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t st_a = '0;
    exp_t st_b = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural reference: plain modulo arithmetic on integers.
    function automatic exp_t model(input exp_t s, input int modulus, input int rstv,
                                   input bit rst, input bit en, input bit up,
                                   input bit load, input int lv);
        exp_t n = '0;
        n.q = s.q;
        if (rst) begin
            n.q = rstv;
        end else if (load) begin
            if (lv < modulus) n.q = lv;
            else begin
                n.q    = modulus - 1;
                n.lerr = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                n.q    = (s.q + 1) % modulus;
                n.wrap = (s.q + 1 >= modulus);
            end else begin
                n.q    = (s.q + modulus - 1) % modulus;
                n.wrap = (s.q == 0);
            end
        end
        n.tc   = up ? (n.q == modulus - 1) : (n.q == 0);
        n.hold = !rst && !load && !en;
        return n;
    endfunction

    task automatic drive(input int sel, input bit rst, input bit en, input bit up,
                         input bit load, input int lv);
        @(negedge clk);
        if (sel == 0) begin
            rst_a = rst; en_a = en; up_a = up; load_a = load; lv_a = 4'(lv);
            st_a = model(st_a, 10, 0, rst, en, up, load, lv);
            exp_a.push_back(st_a);
        end else begin
            rst_b = rst; en_b = en; up_b = up; load_b = load; lv_b = 3'(lv);
            st_b = model(st_b, 8, 5, rst, en, up, load, lv);
            exp_b.push_back(st_b);
        end
    endtask

    // Monitor: results appear one edge after their stimulus; sample 1 time unit past the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                check("a_q", 32'(q_a), e.q);
                check("a_qn", 32'(qn_a), (~e.q) & 32'hF);
                check("a_wrap", 32'(wrap_a), 32'(e.wrap));
                check("a_load_err", 32'(lerr_a), 32'(e.lerr));
                check("a_tc", 32'(tc_a), 32'(e.tc));
                check("a_jk_both", 32'(dut_a.j & dut_a.k), 0);
                if (e.hold) check("a_jk_hold", 32'(dut_a.j | dut_a.k), 0);
            end
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                check("b_q", 32'(q_b), e.q);
                check("b_qn", 32'(qn_b), (~e.q) & 32'h7);
                check("b_wrap", 32'(wrap_b), 32'(e.wrap));
                check("b_load_err", 32'(lerr_b), 32'(e.lerr));
                check("b_tc", 32'(tc_b), 32'(e.tc));
                check("b_jk_both", 32'(dut_b.j & dut_b.k), 0);
                if (e.hold) check("b_jk_hold", 32'(dut_b.j | dut_b.k), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, then count up through the 9->0 wrap.
        repeat (2) drive(0, 1, 0, 1, 0, 0);
        repeat (12) drive(0, 0, 1, 1, 0, 0);
        // Load 0, count down through the 0->9 wrap.
        drive(0, 0, 0, 0, 1, 0);
        repeat (3) drive(0, 0, 1, 0, 0, 0);
        // Load in range with en set, then an out-of-range clamp, then idle.
        drive(0, 0, 1, 1, 1, 7);
        drive(0, 0, 1, 1, 1, 12);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 1, 15);
        drive(0, 0, 1, 0, 0, 0);
        // Reach 5, then reset and load on the same edge.
        drive(0, 0, 0, 1, 1, 4);
        drive(0, 0, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 1, 3);
        // Reset on the edge that would have wrapped.
        drive(0, 0, 0, 1, 1, 9);
        drive(0, 1, 1, 1, 0, 0);
        // Hold at 4 in both directions.
        drive(0, 0, 0, 1, 1, 4);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, i % 2, 0, 0);
        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(0, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 15)));
        end
        drive(0, 0, 0, 1, 0, 0);

        // Full-range configuration: reset to 5, up through 7->0, down through 0->7.
        repeat (2) drive(1, 1, 0, 1, 0, 0);
        repeat (3) drive(1, 0, 1, 1, 0, 0);
        repeat (2) drive(1, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            drive(1, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 7)));
        end
        drive(1, 0, 0, 1, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        check("a_drain", 32'(exp_a.size()), 0);
        check("b_drain", 32'(exp_b.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
